dcache_responder: RTL and testbench

//  Responder (slave) end of the execute-stage data-cache request port: services one load/store at a time from the main pipe.

---
 rtl/dcache_responder.sv | 192 +++++++++++++++++++
 tb/tb_dcache_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache servicing one pipeline load/store at a time.
// Misses write back a dirty victim line, then refill the line in 4 beats over a burst memory bus.
module dcache_responder #(
    parameter int unsigned NUM_SETS   = 256,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_wstrb,
    input  logic [31:0]           req_wdata,
    output logic                  data_ok,
    output logic [31:0]           rdata,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                  mem_rd_rdy,
    input  logic                  mem_ret_valid,
    input  logic                  mem_ret_last,
    input  logic [31:0]           mem_ret_data,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [127:0]          mem_wr_data,
    input  logic                  mem_wr_rdy
);

    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned TAG_W  = ADDR_WIDTH - 4 - IDX_W;
    localparam int unsigned LINE_W = 128;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_WB     = 3'd2;
    localparam logic [2:0] S_RD_REQ = 3'd3;
    localparam logic [2:0] S_REFILL = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]            state_q, state_n;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_wstrb;
    logic [31:0]           r_wdata;
    logic                  hit_q;
    logic [1:0]            cnt_q;

    logic [LINE_W-1:0]     line_q [NUM_SETS];
    logic [TAG_W-1:0]      tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0]   valid_q;
    logic [NUM_SETS-1:0]   dirty_q;

    logic [IDX_W-1:0]      in_idx, r_idx;
    logic [TAG_W-1:0]      in_tag, r_tag;
    logic [1:0]            in_off, r_off;
    logic                  in_hit, victim_dirty, accept, beat, refill_done;
    logic [ADDR_WIDTH-1:0] refill_addr, victim_addr;
    logic                  unused_addr_bits;

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] w;
        w = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) w[8*b +: 8] = new_w[8*b +: 8];
        end
        return w;
    endfunction

    function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line, input logic [1:0] off);
        return line[{off, 5'd0} +: 32];
    endfunction

    assign in_idx           = req_addr[4 +: IDX_W];
    assign in_tag           = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign in_off           = req_addr[3:2];
    assign r_idx            = r_addr[4 +: IDX_W];
    assign r_tag            = r_addr[ADDR_WIDTH-1 -: TAG_W];
    assign r_off            = r_addr[3:2];
    assign unused_addr_bits = ^{req_addr[1:0], r_addr[1:0]};

    assign in_hit       = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
    assign victim_dirty = valid_q[r_idx] && dirty_q[r_idx];
    assign accept       = (state_q == S_IDLE) && req_valid;
    assign beat         = (state_q == S_REFILL) && mem_ret_valid;
    assign refill_done  = beat && mem_ret_last;
    assign refill_addr  = {r_addr[ADDR_WIDTH-1:4], 4'd0};
    assign victim_addr  = {tag_q[r_idx], r_idx, 4'd0};

    // Ready is a decode of the state register, forced low while reset is held.
    assign req_ready = (state_q == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_n = S_LOOKUP;
            S_LOOKUP: begin
                if (hit_q)             state_n = S_IDLE;
                else if (victim_dirty) state_n = S_WB;
                else                   state_n = S_RD_REQ;
            end
            S_WB:     if (mem_wr_rdy) state_n = S_RD_REQ;
            S_RD_REQ: if (mem_rd_rdy) state_n = S_REFILL;
            S_REFILL: if (mem_ret_valid && mem_ret_last) state_n = S_RESP;
            S_RESP:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Request capture, hit flag and refill beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
            hit_q   <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            if (accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wstrb <= req_wstrb;
                r_wdata <= req_wdata;
                hit_q   <= in_hit;
            end
            if ((state_q == S_RD_REQ) && mem_rd_rdy) cnt_q <= 2'd0;
            else if (beat)                           cnt_q <= cnt_q + 2'd1;
        end
    end

    // Hit response is computed at acceptance so data_ok is a flop output during LOOKUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_ok     <= 1'b0;
            rdata       <= '0;
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            data_ok <= (accept && in_hit) || refill_done;
            if (accept && in_hit && !req_we)
                rdata <= word_sel(line_q[in_idx], in_off);
            else if (refill_done && !r_we)
                rdata <= (cnt_q == r_off) ? mem_ret_data : word_sel(line_q[r_idx], r_off);
            else
                rdata <= '0;
            mem_wr_req  <= (state_n == S_WB);
            mem_wr_addr <= (state_n == S_WB) ? victim_addr : '0;
            mem_wr_data <= (state_n == S_WB) ? line_q[r_idx] : '0;
            mem_rd_req  <= (state_n == S_RD_REQ);
            mem_rd_addr <= (state_n == S_RD_REQ) ? refill_addr : '0;
        end
    end

    // Line state; valid is dropped when the refill starts so an aborted refill leaves it invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if ((state_q == S_LOOKUP) && hit_q && r_we) dirty_q[r_idx] <= 1'b1;
            if ((state_q == S_WB) && mem_wr_rdy)         dirty_q[r_idx] <= 1'b0;
            if ((state_q == S_RD_REQ) && mem_rd_rdy)     valid_q[r_idx] <= 1'b0;
            if (refill_done) begin
                valid_q[r_idx] <= 1'b1;
                dirty_q[r_idx] <= r_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((state_q == S_LOOKUP) && hit_q && r_we)
                line_q[r_idx][{r_off, 5'd0} +: 32] <=
                    merge_word(word_sel(line_q[r_idx], r_off), r_wdata, r_wstrb);
            if (beat)
                line_q[r_idx][{cnt_q, 5'd0} +: 32] <=
                    (r_we && (cnt_q == r_off)) ? merge_word(mem_ret_data, r_wdata, r_wstrb)
                                               : mem_ret_data;
            if (refill_done) tag_q[r_idx] <= r_tag;
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: miss/refill, hits, store merge, write-back hold, reset mid-refill, slow memory.
module tb_dcache_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_we;
    logic [31:0]  req_addr;
    logic [3:0]   req_wstrb;
    logic [31:0]  req_wdata;
    logic         data_ok;
    logic [31:0]  rdata;
    logic         mem_rd_req, mem_rd_rdy;
    logic [31:0]  mem_rd_addr;
    logic         mem_ret_valid, mem_ret_last;
    logic [31:0]  mem_ret_data;
    logic         mem_wr_req, mem_wr_rdy;
    logic [31:0]  mem_wr_addr;
    logic [127:0] mem_wr_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dcache_responder #(.NUM_SETS(256), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata), .data_ok(data_ok), .rdata(rdata),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_rdy(mem_rd_rdy),
        .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_rdy(mem_wr_rdy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wd, output bit ok);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        ok = req_ready;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wstrb = strb; req_wdata = wd;
        tick();
        req_valid = 1'b0; req_we = 1'b0; req_wstrb = 4'd0; req_wdata = 32'd0;
    endtask

    task automatic wait_rd_req(output bit ok);
        int n;
        n = 0;
        while (!mem_rd_req && n < 20) begin
            tick();
            n++;
        end
        ok = mem_rd_req;
    endtask

    task automatic serve_refill(input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        mem_rd_rdy = 1'b1;
        tick();
        mem_rd_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ret_valid = 1'b1; mem_ret_data = w[i]; mem_ret_last = (i == 3);
            tick();
        end
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wstrb = 4'd0; req_wdata = 32'd0;
        mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = 32'd0; mem_wr_rdy = 1'b0;
        repeat (3) tick();
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL rst_data_ok got=%b exp=0", data_ok); end
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        checks++; if (mem_rd_req !== 1'b0 || mem_rd_addr !== 32'd0) begin failures++;
            $display("FAIL rst_mem_rd got=%b/%h exp=0/0", mem_rd_req, mem_rd_addr); end
        checks++; if (mem_wr_req !== 1'b0 || mem_wr_addr !== 32'd0 || mem_wr_data !== 128'd0) begin failures++;
            $display("FAIL rst_mem_wr got=%b/%h exp=0/0", mem_wr_req, mem_wr_addr); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_miss_refill();
        bit ok;
        issue(1'b0, 32'h0000_1004, 4'd0, 32'd0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL t1_accept got=0 exp=1"); end
        checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL t1_lookup_data_ok got=%b exp=0", data_ok); end
        wait_rd_req(ok);
        checks++; if (!ok || mem_rd_addr !== 32'h0000_1000) begin failures++;
            $display("FAIL t1_rd_req got=%b/%h exp=1/00001000", mem_rd_req, mem_rd_addr); end
        serve_refill(32'h11, 32'h22, 32'h33, 32'h44);
        checks++; if (data_ok !== 1'b1 || rdata !== 32'h22) begin failures++;
            $display("FAIL t1_resp got=%b/%h exp=1/00000022", data_ok, rdata); end
        tick();
        checks++; if (data_ok !== 1'b0 || req_ready !== 1'b1) begin failures++;
            $display("FAIL t1_idle got=%b/%b exp=0/1", data_ok, req_ready); end
    endtask

    task automatic test_hit_load();
        bit ok;
        issue(1'b0, 32'h0000_1008, 4'd0, 32'd0, ok);
        checks++; if (!ok || data_ok !== 1'b1 || rdata !== 32'h33) begin failures++;
            $display("FAIL t2_hit got=%b/%b/%h exp=1/1/00000033", ok, data_ok, rdata); end
        checks++; if (mem_rd_req !== 1'b0) begin failures++; $display("FAIL t2_no_rd_req got=%b exp=0", mem_rd_req); end
        tick();
        checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL t2_pulse got=%b exp=0", data_ok); end
    endtask

    task automatic test_store_hit();
        bit ok;
        issue(1'b1, 32'h0000_1004, 4'b0011, 32'hAAAA_BBBB, ok);
        checks++; if (!ok || data_ok !== 1'b1 || rdata !== 32'd0) begin failures++;
            $display("FAIL t3_store got=%b/%b/%h exp=1/1/00000000", ok, data_ok, rdata); end
        tick();
        issue(1'b0, 32'h0000_1004, 4'd0, 32'd0, ok);
        checks++; if (!ok || data_ok !== 1'b1 || rdata !== 32'h0000_BBBB) begin failures++;
            $display("FAIL t3_load_merged got=%b/%b/%h exp=1/1/0000bbbb", ok, data_ok, rdata); end
        tick();
    endtask

    task automatic test_writeback();
        bit ok;
        logic [127:0] exp_line;
        exp_line = {32'h44, 32'h33, 32'h0000_BBBB, 32'h11};
        issue(1'b0, 32'h0000_2004, 4'd0, 32'd0, ok);
        checks++; if (!ok || data_ok !== 1'b0) begin failures++; $display("FAIL t4_miss got=%b/%b exp=1/0", ok, data_ok); end
        tick();
        checks++; if (mem_wr_req !== 1'b1 || mem_wr_addr !== 32'h0000_1000 || mem_wr_data !== exp_line) begin
            failures++; $display("FAIL t4_wb got=%b/%h/%h exp=1/00001000/%h", mem_wr_req, mem_wr_addr, mem_wr_data, exp_line); end
        checks++; if (mem_rd_req !== 1'b0) begin failures++; $display("FAIL t4_rd_before_wb got=%b exp=0", mem_rd_req); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_wr_req !== 1'b1 || mem_wr_addr !== 32'h0000_1000 || mem_wr_data !== exp_line) begin
                failures++; $display("FAIL t4_wb_hold%0d got=%b/%h/%h exp=1/00001000/%h", i, mem_wr_req, mem_wr_addr, mem_wr_data, exp_line); end
        end
        mem_wr_rdy = 1'b1;
        tick();
        mem_wr_rdy = 1'b0;
        checks++; if (mem_wr_req !== 1'b0 || mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h0000_2000) begin failures++;
            $display("FAIL t4_after_wb got=%b/%b/%h exp=0/1/00002000", mem_wr_req, mem_rd_req, mem_rd_addr); end
        serve_refill(32'h55, 32'h66, 32'h77, 32'h88);
        checks++; if (data_ok !== 1'b1 || rdata !== 32'h66) begin failures++;
            $display("FAIL t4_resp got=%b/%h exp=1/00000066", data_ok, rdata); end
        tick();
    endtask

    task automatic test_reset_mid_refill();
        bit ok;
        issue(1'b0, 32'h0000_3008, 4'd0, 32'd0, ok);
        wait_rd_req(ok);
        checks++; if (!ok || mem_rd_addr !== 32'h0000_3000) begin failures++;
            $display("FAIL t5_rd_req got=%b/%h exp=1/00003000", mem_rd_req, mem_rd_addr); end
        mem_rd_rdy = 1'b1; tick(); mem_rd_rdy = 1'b0;
        mem_ret_valid = 1'b1; mem_ret_data = 32'hC0; tick();
        mem_ret_data = 32'hC1; tick();
        rst = 1'b1; mem_ret_data = 32'hC2;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL t5_ready_in_rst got=%b exp=0", req_ready); end
        tick();
        rst = 1'b0; mem_ret_data = 32'hC3; mem_ret_last = 1'b1;
        tick();
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = 32'd0;
        checks++; if (data_ok !== 1'b0 || req_ready !== 1'b1 || mem_rd_req !== 1'b0) begin failures++;
            $display("FAIL t5_stray_beats got=%b/%b/%b exp=0/1/0", data_ok, req_ready, mem_rd_req); end
        issue(1'b0, 32'h0000_3008, 4'd0, 32'd0, ok);
        checks++; if (!ok || data_ok !== 1'b0) begin failures++; $display("FAIL t5_remiss got=%b/%b exp=1/0", ok, data_ok); end
        tick();
        checks++; if (mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h0000_3000) begin failures++;
            $display("FAIL t5_rd_again got=%b/%h exp=1/00003000", mem_rd_req, mem_rd_addr); end
        serve_refill(32'hD0, 32'hD1, 32'hD2, 32'hD3);
        checks++; if (data_ok !== 1'b1 || rdata !== 32'hD2) begin failures++;
            $display("FAIL t5_resp got=%b/%h exp=1/000000d2", data_ok, rdata); end
        tick();
    endtask

    task automatic test_slow_mem();
        bit ok;
        int pulses;
        logic [31:0] got_rdata;
        pulses = 0; got_rdata = 32'd0;
        issue(1'b0, 32'h0000_4008, 4'd0, 32'd0, ok);
        mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = 32'hDEAD;
        tick();
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = 32'd0;
        checks++; if (!ok || mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h0000_4000 || data_ok !== 1'b0) begin failures++;
            $display("FAIL t6_rd_req got=%b/%b/%h/%b exp=1/1/00004000/0", ok, mem_rd_req, mem_rd_addr, data_ok); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h0000_4000) begin failures++;
                $display("FAIL t6_rd_hold%0d got=%b/%h exp=1/00004000", i, mem_rd_req, mem_rd_addr); end
        end
        mem_rd_rdy = 1'b1; tick(); mem_rd_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ret_valid = 1'b0;
            repeat (2) begin
                tick();
                if (data_ok) begin pulses++; got_rdata = rdata; end
            end
            mem_ret_valid = 1'b1; mem_ret_data = 32'hA0 + 32'(i); mem_ret_last = (i == 3);
            tick();
            if (data_ok) begin pulses++; got_rdata = rdata; end
            if (i < 3) begin
                checks++; if (pulses != 0) begin failures++; $display("FAIL t6_early_ok beat=%0d got=%0d exp=0", i, pulses); end
            end
        end
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = 32'd0;
        checks++; if (data_ok !== 1'b1) begin failures++; $display("FAIL t6_ok_after_last got=%b exp=1", data_ok); end
        repeat (3) begin
            tick();
            if (data_ok) begin pulses++; got_rdata = rdata; end
        end
        checks++; if (pulses != 1 || got_rdata !== 32'hA2) begin failures++;
            $display("FAIL t6_single_pulse got=%0d/%h exp=1/000000a2", pulses, got_rdata); end
    endtask

    task automatic test_zero_strb_store();
        bit ok;
        logic [127:0] exp_line;
        exp_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        issue(1'b1, 32'h0000_4004, 4'b0000, 32'hFFFF_FFFF, ok);
        checks++; if (!ok || data_ok !== 1'b1) begin failures++; $display("FAIL t7_store_hit got=%b/%b exp=1/1", ok, data_ok); end
        tick();
        issue(1'b0, 32'h0000_5000, 4'd0, 32'd0, ok);
        tick();
        checks++; if (mem_wr_req !== 1'b1 || mem_wr_addr !== 32'h0000_4000 || mem_wr_data !== exp_line) begin failures++;
            $display("FAIL t7_dirty_wb got=%b/%h/%h exp=1/00004000/%h", mem_wr_req, mem_wr_addr, mem_wr_data, exp_line); end
        mem_wr_rdy = 1'b1; tick(); mem_wr_rdy = 1'b0;
        serve_refill(32'hE0, 32'hE1, 32'hE2, 32'hE3);
        checks++; if (data_ok !== 1'b1 || rdata !== 32'hE0) begin failures++;
            $display("FAIL t7_resp got=%b/%h exp=1/000000e0", data_ok, rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_miss_refill();
        test_hit_load();
        test_store_hit();
        test_writeback();
        test_reset_mid_refill();
        test_slow_mem();
        test_zero_strb_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
